// File: rtl/pps_gen.sv
// pps_gen: decade-selectable pulse train (1 s .. 100 ns, 10 % duty) plus a one-cycle start-of-period strobe; PPS_SIM_FAST_EN shortens all periods for simulation.
// Latency: pps_out/pulse_out are registered, one cycle behind the period counter; first pulse appears one cycle after enable.
// Backpressure: none; free-running while pps_en_i is high, immediately idle (outputs low) when it drops.
module pps_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [2:0] pps_sel_i,
    input  logic       pps_en_i,
    output logic       pps_out,
    output logic       pulse_out
);

    typedef logic [CNT_W-1:0] cnt_t;

    // Period length in cycles for a given select; evaluated only at elaboration.
    function automatic longint unsigned period_cycles(input int unsigned sel);
        longint unsigned p;
        p = 64'(CLK_FREQ_HZ);
        for (int unsigned i = 0; i < sel; i++) begin
            p = p / 64'd10;
        end
`ifdef PPS_SIM_FAST_EN
        p = p / 64'd1000;
        if (p < 64'd10) begin
            p = 64'd10;
        end
`endif
        return p;
    endfunction

    // Terminal count (period - 1), so the wrap compare needs no runtime subtract.
    function automatic cnt_t last_of(input int unsigned sel);
        return cnt_t'(period_cycles(sel) - 64'd1);
    endfunction

    // High-phase length: pps_out is high while cnt is below this.
    function automatic cnt_t high_of(input int unsigned sel);
        return cnt_t'(period_cycles(sel) / 64'd10);
    endfunction

    localparam cnt_t LAST_TBL [8] = '{
        last_of(0), last_of(1), last_of(2), last_of(3),
        last_of(4), last_of(5), last_of(6), last_of(7)
    };

    localparam cnt_t HIGH_TBL [8] = '{
        high_of(0), high_of(1), high_of(2), high_of(3),
        high_of(4), high_of(5), high_of(6), high_of(7)
    };

    cnt_t       cnt;
    logic [2:0] sel_q;
    cnt_t       cnt_last;
    cnt_t       cnt_high;

    // Look up the active period's limits from the constant tables.
    always_comb begin
        cnt_last = LAST_TBL[sel_q];
        cnt_high = HIGH_TBL[sel_q];
    end

    // Period counter and registered outputs; select is only sampled at a period boundary or while idle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt       <= '0;
            sel_q     <= 3'd0;
            pps_out   <= 1'b0;
            pulse_out <= 1'b0;
        end else if (!pps_en_i) begin
            cnt       <= '0;
            sel_q     <= pps_sel_i;
            pps_out   <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            pulse_out <= (cnt == '0);
            pps_out   <= (cnt < cnt_high);
            if (cnt == cnt_last) begin
                cnt   <= '0;
                sel_q <= pps_sel_i;
            end else begin
                cnt <= cnt + cnt_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_pps_gen.sv
module tb_pps_gen;

    localparam int unsigned CLK_HZ = 100_000_000;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [2:0] pps_sel_i;
    logic       pps_en_i;
    logic       pps_out;
    logic       pulse_out;

    int n_cmp  = 0;
    int n_fail = 0;

    pps_gen #(
        .CLK_FREQ_HZ(CLK_HZ),
        .CNT_W      (32)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .pps_sel_i(pps_sel_i),
        .pps_en_i (pps_en_i),
        .pps_out  (pps_out),
        .pulse_out(pulse_out)
    );

    always #5 aclk = ~aclk;

    // Reference period: clock rate divided by ten to the power of select.
    function automatic longint per_of(input int s);
        longint ten;
        longint p;
        ten = 64'd10;
        p = longint'(CLK_HZ) / (ten ** s);
`ifdef PPS_SIM_FAST_EN
        p = p / 1000;
        if (p < 10) p = 10;
`endif
        return p;
    endfunction

    // Timestamp model: a period is an interval [start, start+len); outputs follow from the offset into it.
    longint cyc     = 0;
    longint start   = 0;
    longint cur_p   = 0;
    longint pos     = 0;
    bit     running = 1'b0;
    int     lat_sel = 0;
    bit     exp_pps = 1'b0;
    bit     exp_pul = 1'b0;

    always @(posedge aclk) begin
        if (!aresetn) begin
            running = 1'b0;
            lat_sel = 0;
            exp_pps = 1'b0;
            exp_pul = 1'b0;
        end else if (!pps_en_i) begin
            running = 1'b0;
            lat_sel = int'(pps_sel_i);
            exp_pps = 1'b0;
            exp_pul = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                start   = cyc;
                cur_p   = per_of(lat_sel);
            end
            pos     = cyc - start;
            exp_pul = (pos == 0);
            exp_pps = (pos < cur_p / 10);
            if (pos == cur_p - 1) begin
                lat_sel = int'(pps_sel_i);
                start   = cyc + 1;
                cur_p   = per_of(lat_sel);
            end
        end
        cyc = cyc + 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    bit ep, eu;
    always @(negedge aclk) begin
        ep = aresetn ? exp_pps : 1'b0;
        eu = aresetn ? exp_pul : 1'b0;
        n_cmp = n_cmp + 1;
        if (pps_out !== ep) begin
            n_fail = n_fail + 1;
            $display("FAIL model_pps t=%0t got %b want %b", $time, pps_out, ep);
        end
        n_cmp = n_cmp + 1;
        if (pulse_out !== eu) begin
            n_fail = n_fail + 1;
            $display("FAIL model_pulse t=%0t got %b want %b", $time, pulse_out, eu);
        end
    end

    task automatic check(input string name, input logic got, input logic want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s t=%0t got %b want %b", name, $time, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    bit sp [210];
    bit su [210];

    initial begin
        aresetn   = 1'b0;
        pps_en_i  = 1'b0;
        pps_sel_i = 3'd0;

        // Reset held for 100 ns with enable low.
        cycles(10);
        check("reset_pps", pps_out, 1'b0);
        check("reset_pulse", pulse_out, 1'b0);
        aresetn = 1'b1;

        // Fresh enable at select 6; capture the first two periods for literal checks.
        pps_sel_i = 3'd6;
        cycles(2);
        check("idle_pps", pps_out, 1'b0);
        pps_en_i = 1'b1;
        for (int k = 0; k < 210; k++) begin
            @(negedge aclk);
            sp[k] = pps_out;
            su[k] = pulse_out;
        end
        check("first_pps_rise", sp[0], 1'b1);
        check("first_pulse", su[0], 1'b1);
        check("pulse_one_wide", su[1], 1'b0);
`ifdef PPS_SIM_FAST_EN
        check("fast_high_end", sp[1], 1'b0);
        check("fast_second_rise", sp[10], 1'b1);
        check("fast_second_pulse", su[10], 1'b1);
`else
        check("high_last", sp[9], 1'b1);
        check("high_end", sp[10], 1'b0);
        check("low_before_wrap", sp[99], 1'b0);
        check("second_rise", sp[100], 1'b1);
        check("second_pulse", su[100], 1'b1);
        check("second_pulse_width", su[101], 1'b0);
        check("third_rise", sp[200], 1'b1);
`endif

        // Select change mid-period: current period must complete before the new one applies.
        pps_sel_i = 3'd5;
        cycles(1300);

        // Shortest period: pps_out and pulse_out coincide.
        pps_sel_i = 3'd7;
        cycles(1100);
        check("sel7_same", pps_out, pulse_out);

        // Enable dropped mid high-phase, then raised again.
        pps_sel_i = 3'd5;
        cycles(20);
        for (int i = 0; i < 1100 && !pulse_out; i++) @(negedge aclk);
        check("wait_pulse", pulse_out, 1'b1);
        cycles(3);
        check("mid_high", pps_out, 1'b1);
        pps_en_i = 1'b0;
        @(negedge aclk);
        check("drop_pps", pps_out, 1'b0);
        check("drop_pulse", pulse_out, 1'b0);
        cycles(7);
        pps_en_i = 1'b1;
        @(negedge aclk);
        check("reen_pps", pps_out, 1'b1);
        check("reen_pulse", pulse_out, 1'b1);

        // Asynchronous reset pulse during the high phase.
        cycles(3);
        @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        check("arst_pps", pps_out, 1'b0);
        check("arst_pulse", pulse_out, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_pulse", pulse_out, 1'b1);
        cycles(50);
        check("post_rst_high", pps_out, 1'b1);
        pps_en_i = 1'b0;
        cycles(2);

        // Randomized enable/select segments.
        for (int seg = 0; seg < 40; seg++) begin
            pps_en_i = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) pps_sel_i = 3'($urandom_range(5, 7));
            cycles($urandom_range(5, 1200));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pps_gen.md
# pps_gen

Programmable pulse-per-second generator running from the 100 MHz system clock. It produces a periodic pulse train, `pps_out`, with a 10 % duty cycle and a period selected by `pps_sel_i` in decade steps from 1 s down to 100 ns. Alongside it, `pulse_out` is a one-cycle strobe marking the start of each period. The block sits at the timing/sync layer, feeding time-tagging and sampling logic.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: aclk frequency. Must be a multiple of 10_000_000.
- `CNT_W`, default 32: period counter width. Must hold `CLK_FREQ_HZ-1`.
- `aclk`  in  1: system clock, 100 MHz nominal.
- `aresetn`  in  1: asynchronous, active-low reset.
- `pps_sel_i`  in  3: period select. Period = 1 s / 10^sel (0 → 1 s … 7 → 100 ns).
- `pps_en_i`  in  1: generator enable, level sensitive.
- `pps_out`  out  1: periodic pulse, high for the first period/10 cycles of each period.
- `pulse_out`  out  1: single-cycle strobe at the start of each period.

## Operation
- Period in cycles: P(sel) = CLK_FREQ_HZ / 10^sel.
  - At 100 MHz: 100_000_000, 10_000_000, 1_000_000, 100_000, 10_000, 1_000, 100, 10.
  - High width: H(sel) = P(sel)/10.
- P and H come from an elaboration-time table. No runtime division.
- Registers:
  - `cnt` (`CNT_W` bits): position in the current period.
  - `sel_q` (3 bits): the active select.
- Disabled (`pps_en_i`=0):
  - `cnt` ← 0 and `sel_q` ← `pps_sel_i` every cycle.
  - `pps_out` ← 0 and `pulse_out` ← 0.
- Enabled (`pps_en_i`=1):
  - `pulse_out` ← (`cnt`==0).
  - `pps_out` ← (`cnt` < H(`sel_q`)).
  - If `cnt` == P(`sel_q`)-1: `cnt` ← 0 and `sel_q` ← `pps_sel_i`. Otherwise `cnt` ← `cnt`+1.
- A `pps_sel_i` change while enabled takes effect only at the next period boundary. There are no runt or stretched periods.
- Deassertion of enable mid-period aborts the period immediately. Re-enabling starts a fresh period at `cnt`=0.
- `pps_sel_i` is static-quasi and is treated as synchronous to `aclk`. No CDC is provided.

## Timing
- Reset values: `pps_out`=0, `pulse_out`=0, `cnt`=0, `sel_q`=0.
- All outputs are registered, with one cycle of latency from `cnt`.
- First enabled edge E:
  - `pps_out` and `pulse_out` rise after E.
  - `pulse_out` falls after E+1.
  - `pps_out` falls after E+H.
- Subsequent rising edges of `pps_out` occur exactly every P(`sel_q`) cycles. `pulse_out` is high for exactly 1 cycle per period.
- At sel=7 (P=10, H=1), `pps_out` and `pulse_out` are identical.
- Reset asserted mid-operation clears all state asynchronously. After reset release, behaviour is as for a fresh enable.

## Configuration
- `PPS_SIM_FAST_EN`: simulation speed-up.
  - Defined: P'(sel) = max(P(sel)/1000, 10) and H' = P'/10. At 100 MHz, sel 0 gives 100_000 cycles (1 ms), sel 1 gives 10_000, sel 2 gives 1_000, sel 3 gives 100, and sel 4–7 give 10.
  - Undefined: true periods as above. This is the synthesis default.

## Test plan
- Reset held 100 ns, en=0 → `pps_out`=`pulse_out`=0 throughout.
- en→1 at sel=0 with `PPS_SIM_FAST_EN` → `pps_out` rises 1 cycle after enable, is high 10_000 cycles, and repeats every 100_000 cycles (1 ms). `pulse_out` is 1 cycle wide at each rise.
- sel changed 0→1 mid-period at 1 ms → current 100_000-cycle period completes, then period becomes 10_000 with high 1_000.
- sel=7 without macro → 10-cycle period, 1-cycle-high `pps_out` equal to `pulse_out`.
- en dropped mid-high-phase, then re-raised → outputs low next cycle, and a new full period starts 1 cycle after re-enable.
- `aresetn` pulsed low mid-period → outputs 0 immediately (asynchronously), then restart from `cnt`=0.
